// File: rtl/serial_bit_feeder_pkg.sv
// feeder_pkg: definitions shared by the serial bit feeder and the benches
// that drive the downstream "101" sequence detector.
//   state_t              : feeder FSM state encoding (IDLE / SHIFT / GAP)
//   FEEDER_DEFAULT_WIDTH : default word width, also used by the detector bench
//   GAP_CNT_W            : width of the inter-word gap counter (gap up to 15)
package feeder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_GAP   = 2'b10
    } state_t;

    localparam int FEEDER_DEFAULT_WIDTH = 8;
    localparam int GAP_CNT_W            = 4;

endpackage

// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder: parallel-in / serial-out stage feeding a 1-bit sequence
// detector. Accepts a WIDTH-bit word over valid/ready and shifts it out one
// bit per clock, driving IDLE_LEVEL between words and an optional gap.
// Ports:
//   clk       : clock, all state changes on posedge
//   reset     : asynchronous, active-low reset
//   in_data   : parallel word to serialise
//   in_valid  : upstream word is valid
//   in_ready  : feeder accepts a word on the next posedge
//   x_out     : serial bit stream (detector x input)
//   bit_valid : x_out carries a data bit this cycle
//   word_done : last bit of the current word is on x_out
//   busy      : feeder is not idle
module serial_bit_feeder
    import feeder_pkg::*;
#(
    parameter int   WIDTH      = FEEDER_DEFAULT_WIDTH,
    parameter int   MSB_FIRST  = 1,
    parameter int   GAP_CYCLES = 0,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             x_out,
    output logic             bit_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int CNT_W   = $clog2(WIDTH);
    localparam int OUT_IDX = (MSB_FIRST != 0) ? WIDTH - 1 : 0;
    localparam bit HAS_GAP = (GAP_CYCLES > 0);

    localparam logic [CNT_W-1:0]     LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'(HAS_GAP ? GAP_CYCLES - 1 : 0);

    state_t                 state_reg, state_next;
    logic [WIDTH-1:0]       shift_reg, shift_next;
    logic [CNT_W-1:0]       bit_cnt_reg, bit_cnt_next;
    logic [GAP_CNT_W-1:0]   gap_cnt_reg, gap_cnt_next;

    logic [WIDTH-1:0]       shifted;
    logic                   accept;
    logic                   last_bit;

    // Shift one position toward the output end; the vacated end fills with 0.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (MSB_FIRST != 0) begin : g_msb
                if (gi == 0) begin : g_end
                    assign shifted[gi] = 1'b0;
                end else begin : g_mid
                    assign shifted[gi] = shift_reg[gi-1];
                end
            end else begin : g_lsb
                if (gi == WIDTH - 1) begin : g_end
                    assign shifted[gi] = 1'b0;
                end else begin : g_mid
                    assign shifted[gi] = shift_reg[gi+1];
                end
            end
        end
    endgenerate

    assign last_bit = (state_reg == ST_SHIFT) && (bit_cnt_reg == LAST_BIT);
    assign accept   = in_valid && in_ready;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (last_bit) begin
                    if (HAS_GAP) begin
                        state_next = ST_GAP;
                    end else if (accept) begin
                        // Back-to-back: next word loads on the retiring edge.
                        state_next = ST_SHIFT;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_reg == GAP_LAST) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath: shift register, bit counter and gap counter
    always_comb begin
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt_reg;
        gap_cnt_next = gap_cnt_reg;
        if (accept) begin
            shift_next   = in_data;
            bit_cnt_next = '0;
        end else if (state_reg == ST_SHIFT) begin
            shift_next = shifted;
            if (last_bit) begin
                // Hold at WIDTH-1 rather than wrapping; arm the gap counter.
                gap_cnt_next = '0;
            end else begin
                bit_cnt_next = bit_cnt_reg + CNT_W'(1);
            end
        end
        if (state_reg == ST_GAP) begin
            gap_cnt_next = gap_cnt_reg + GAP_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            gap_cnt_reg <= '0;
        end else begin
            shift_reg   <= shift_next;
            bit_cnt_reg <= bit_cnt_next;
            gap_cnt_reg <= gap_cnt_next;
        end
    end

    // Outputs depend on registered state only
    assign bit_valid = (state_reg == ST_SHIFT);
    assign word_done = last_bit;
    assign x_out     = bit_valid ? shift_reg[OUT_IDX] : IDLE_LEVEL;
    assign in_ready  = (state_reg == ST_IDLE) || (word_done && !HAS_GAP);
    assign busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Bench for serial_bit_feeder. Three instances cover MSB-first with no gap,
// MSB-first with a 3-cycle gap, and LSB-first with IDLE_LEVEL = 1. One
// driver feeds the selected instance; a monitor compares every cycle against
// expectations queued at accept time and a timeline derived from the last
// accept edge.
module tb_serial_bit_feeder;
    import feeder_pkg::*;

    localparam int W    = FEEDER_DEFAULT_WIDTH;
    localparam int NCFG = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic [1:0]   sel = 2'd0;

    logic [NCFG-1:0] rdy_w, x_w, bv_w, wd_w, busy_w;

    always #5 clk = ~clk;

    serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1), .GAP_CYCLES(0), .IDLE_LEVEL(1'b0)) u_cfg0 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid && sel == 2'd0),
        .in_ready(rdy_w[0]), .x_out(x_w[0]), .bit_valid(bv_w[0]), .word_done(wd_w[0]), .busy(busy_w[0])
    );
    serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1), .GAP_CYCLES(3), .IDLE_LEVEL(1'b0)) u_cfg1 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid && sel == 2'd1),
        .in_ready(rdy_w[1]), .x_out(x_w[1]), .bit_valid(bv_w[1]), .word_done(wd_w[1]), .busy(busy_w[1])
    );
    serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(0), .GAP_CYCLES(0), .IDLE_LEVEL(1'b1)) u_cfg2 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid && sel == 2'd2),
        .in_ready(rdy_w[2]), .x_out(x_w[2]), .bit_valid(bv_w[2]), .word_done(wd_w[2]), .busy(busy_w[2])
    );

    logic cur_rdy, cur_x, cur_bv, cur_wd, cur_busy;
    assign cur_rdy  = rdy_w[sel];
    assign cur_x    = x_w[sel];
    assign cur_bv   = bv_w[sel];
    assign cur_wd   = wd_w[sel];
    assign cur_busy = busy_w[sel];

    function automatic int cfg_gap(input logic [1:0] s);
        return (s == 2'd1) ? 3 : 0;
    endfunction
    function automatic int cfg_msb(input logic [1:0] s);
        return (s == 2'd2) ? 0 : 1;
    endfunction
    function automatic logic cfg_idle(input logic [1:0] s);
        return (s == 2'd2) ? 1'b1 : 1'b0;
    endfunction

    // i-th transmitted bit of a word, straight from the bit-order rule
    function automatic logic exp_bit(input logic [W-1:0] w, input int i, input int msb);
        return (msb != 0) ? w[W-1-i] : w[i];
    endfunction

    typedef struct {
        int   cyc;
        logic bitv;
        logic done;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   last_k = -1000;
    int   prev_k = -1000;
    bit   done = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic act, input logic req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s cfg=%0d cyc=%0d actual=%b required=%b", name, sel, cyc, act, req);
        end
    endtask

    // Monitor: samples at negedge, away from the active edge
    initial begin
        exp_t e;
        int   kk, g;
        logic exp_busy, exp_rdy;
        forever begin
            @(negedge clk);
            if (!done) begin
                if (!reset) begin
                    sb.delete();
                    chk("rst_x_out", cur_x, cfg_idle(sel));
                    chk("rst_bit_valid", cur_bv, 1'b0);
                    chk("rst_word_done", cur_wd, 1'b0);
                    chk("rst_busy", cur_busy, 1'b0);
                    chk("rst_in_ready", cur_rdy, 1'b1);
                end else begin
                    // Accept edges later than now belong to a word not yet loaded.
                    kk = (last_k <= cyc) ? last_k : prev_k;
                    g  = cfg_gap(sel);
                    exp_busy = (cyc < kk + W + g);
                    exp_rdy  = (g == 0) ? (cyc >= kk + W - 1) : (cyc >= kk + W + g);
                    while (sb.size() > 0 && sb[0].cyc < cyc) begin
                        e = sb.pop_front();
                        vectors++;
                        miscompares++;
                        $display("FAIL lost_bit cfg=%0d cyc=%0d actual=missing required=bit_for_cyc_%0d", sel, cyc, e.cyc);
                    end
                    if (sb.size() > 0 && sb[0].cyc == cyc) begin
                        e = sb.pop_front();
                        chk("bit_valid", cur_bv, 1'b1);
                        chk("x_out", cur_x, e.bitv);
                        chk("word_done", cur_wd, e.done);
                    end else begin
                        chk("idle_bit_valid", cur_bv, 1'b0);
                        chk("idle_x_out", cur_x, cfg_idle(sel));
                        chk("idle_word_done", cur_wd, 1'b0);
                    end
                    chk("busy", cur_busy, exp_busy);
                    chk("in_ready", cur_rdy, exp_rdy);
                end
            end
        end
    end

    // Offer a word; while not ready, in_data carries junk that must be ignored.
    // Called at a negedge; returns at the negedge following the accept edge.
    task automatic send(input logic [W-1:0] w);
        int t;
        t = 0;
        in_valid = 1'b1;
        while (!cur_rdy) begin
            in_data = W'($urandom);
            @(negedge clk);
            t++;
            if (t > 100) begin
                $display("FAIL accept_timeout cfg=%0d cyc=%0d actual=in_ready_low required=in_ready_high", sel, cyc);
                $fatal(1, "accept timeout");
            end
        end
        in_data = w;
        prev_k = last_k;
        last_k = cyc + 1;
        for (int i = 0; i < W; i++) begin
            sb.push_back('{cyc + 1 + i, exp_bit(w, i, cfg_msb(sel)), (i == W - 1)});
        end
        $display("word cfg=%0d data=%h accept_edge=%0d", sel, w, cyc + 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        for (int s = 0; s < NCFG; s++) begin
            #1;
            sel    = 2'(s);
            reset  = 1'b0;
            last_k = -1000;
            prev_k = -1000;
            repeat (2) @(negedge clk);
            @(posedge clk);
            #1 reset = 1'b1;
            @(negedge clk);
            idle(5);
            case (s)
                0: begin
                    send(8'hA5);
                    idle(3);
                    send(8'hA5);
                    send(8'h80);
                    idle(3);
                    // Abort mid-word while the 4th bit is on x_out.
                    send(8'hA5);
                    repeat (3) @(posedge clk);
                    #1;
                    reset  = 1'b0;
                    last_k = -1000;
                    prev_k = -1000;
                    @(negedge clk);
                    @(posedge clk);
                    #1 reset = 1'b1;
                    @(negedge clk);
                    send(8'h5A);
                end
                1: begin
                    send(8'hFF);
                    send(8'hFF);
                end
                default: begin
                    send(8'h01);
                end
            endcase
            for (int n = 0; n < 12; n++) begin
                idle(($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0);
                send(W'($urandom));
            end
            idle(W + 8);
        end
        done = 1'b1;
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_bit_feeder.md
Name: serial_bit_feeder

Overview:
- Parallel-in / serial-out stage sitting directly upstream of the serial "101" Mealy sequence detector.
- Accepts a WIDTH-bit word over a valid/ready handshake and drives it onto the detector's 1-bit input x, one bit per clk.
- Drives a programmable idle level between words, plus an optional inter-word gap.
- Provides bit_valid / word_done qualifiers so downstream logic can tell real data bits from idle filler.

Parameters:
- WIDTH, 8, word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first; 0 = bit 0 first.
- GAP_CYCLES, 0, idle cycles inserted after each word's last bit; legal range 0..15.
- IDLE_LEVEL, 0, value driven on x_out when no data bit is being sent.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- in_data  input  WIDTH  parallel word to serialise.
- in_valid  input  1  upstream asserts when in_data is valid.
- in_ready  output  1  feeder can accept a word this cycle.
- x_out  output  1  serial bit; connects to the detector's x.
- bit_valid  output  1  x_out carries a data bit this cycle.
- word_done  output  1  high during the cycle the last bit of a word is on x_out.
- busy  output  1  state is not IDLE.

Behaviour:
- Reset: state IDLE, shift register 0, bit counter 0, gap counter 0. x_out = IDLE_LEVEL, bit_valid = 0, word_done = 0, busy = 0, in_ready = 1.
- Reset asserted mid-word or mid-gap: abort immediately (asynchronous) and return to the reset values. The partial word is discarded.
- State machine states: IDLE, SHIFT, GAP.
- IDLE -> SHIFT: on a posedge with in_valid && in_ready.
  - in_data is loaded into the shift register; the bit counter is cleared to 0.
- SHIFT: each posedge shifts one bit toward the output end and increments the counter.
  - When counter = WIDTH-1 and GAP_CYCLES > 0: go to GAP, gap counter cleared.
  - When counter = WIDTH-1 and GAP_CYCLES = 0: go to SHIFT if a new word is accepted on that edge, else IDLE.
- GAP: gap counter increments each posedge; go to IDLE when it reaches GAP_CYCLES-1.
- Outputs are combinational from registered state only, with no dependence on in_valid:
  - x_out = shift-register output bit (MSB if MSB_FIRST, else LSB) in SHIFT; IDLE_LEVEL otherwise.
  - bit_valid = (state == SHIFT).
  - word_done = (state == SHIFT && counter == WIDTH-1).
  - in_ready = IDLE || (word_done && GAP_CYCLES == 0).
  - busy = (state != IDLE).
- Latency: word accepted at edge k.
  - First bit is on x_out from edge k to edge k+1.
  - Last bit is on x_out from edge k+WIDTH-1 to edge k+WIDTH.
  - Throughput with GAP_CYCLES = 0 is one word per WIDTH cycles, with no bubble.
- Back-to-back: with GAP_CYCLES = 0 and in_valid held, the next word loads on the same edge that retires the last bit. The bitstream is continuous, so detector patterns can span a word boundary; this is intended.
- in_valid while in_ready = 0: ignored, in_data is not sampled. Upstream must hold in_valid and in_data until accepted.
- Counter width is $clog2(WIDTH). The counter never wraps past WIDTH-1.

Decomposition:
- Shared package (feeder_pkg): state encoding constants ST_IDLE = 2'b00, ST_SHIFT = 2'b01, ST_GAP = 2'b10.
- Same package: a default-width constant reused by the detector testbench.
- No sub-module. A single module of roughly 150 lines, containing:
  - a state register block,
  - a next-state block,
  - a datapath block (shift register and counters),
  - an output assign block.

Test Plan:
- Reset then idle, GAP_CYCLES = 0, IDLE_LEVEL = 0, in_valid = 0 for 5 cycles -> x_out = 0, bit_valid = 0, busy = 0, in_ready = 1 throughout.
- Load 8'hA5, MSB_FIRST = 1 -> x_out = 1,0,1,0,0,1,0,1 on 8 consecutive cycles, bit_valid = 1, word_done only on the 8th cycle.
  - With the detector attached, its y = 1 on bits 3 and 8.
- Back-to-back 8'hA5 then 8'h80, in_valid held -> 16 contiguous valid bits, in_ready high only on the two word_done cycles plus IDLE, no bubble between words.
- GAP_CYCLES = 3, load 8'hFF twice -> 8 ones, 3 cycles of IDLE_LEVEL with bit_valid = 0, then the second word.
  - in_ready low from the first accept until the gap ends.
- MSB_FIRST = 0, load 8'h01 -> x_out = 1,0,0,0,0,0,0,0.
- Reset pulsed low at bit 4 of 8'hA5 -> x_out = IDLE_LEVEL and busy = 0 immediately; after release, a new word 8'h5A serialises cleanly as 0,1,0,1,1,0,1,0.
